// File: rtl/max7219_chain_tx_pkg.sv
// max7219_pkg: shared definitions for the MAX7219 chain transmitter.
//   - register address constants of the MAX7219
//   - FSM state encoding used by max7219_chain_tx
//   - reg_word(): builds the 16-bit word for one device write
package max7219_pkg;

  localparam logic [3:0] NOOP       = 4'h0;
  localparam logic [3:0] DIGIT0     = 4'h1;
  localparam logic [3:0] DIGIT1     = 4'h2;
  localparam logic [3:0] DIGIT2     = 4'h3;
  localparam logic [3:0] DIGIT3     = 4'h4;
  localparam logic [3:0] DIGIT4     = 4'h5;
  localparam logic [3:0] DIGIT5     = 4'h6;
  localparam logic [3:0] DIGIT6     = 4'h7;
  localparam logic [3:0] DIGIT7     = 4'h8;
  localparam logic [3:0] DECODE     = 4'h9;
  localparam logic [3:0] INTENSITY  = 4'hA;
  localparam logic [3:0] SCAN_LIMIT = 4'hB;
  localparam logic [3:0] SHUTDOWN   = 4'hC;
  localparam logic [3:0] TEST       = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_TAIL  = 3'd2,
    ST_LATCH = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Upper nibble is don't-care on the MAX7219 and is always sent as zero.
  function automatic logic [15:0] reg_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_chain_tx_if.sv
// max7219_chain_tx_if: register-write request channel into the chain transmitter.
//   i_valid      write request
//   o_ready      transmitter idle; a write is taken when i_valid & o_ready
//   i_addr       MAX7219 register address
//   i_data       register data
//   i_dev        target device index (DEV_W bits)
//   i_broadcast  write the same word to every device
// master drives the request, slave (the transmitter) drives o_ready.
interface max7219_chain_tx_if #(
  parameter int DEV_W = 1
);
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_addr;
  logic [7:0]       i_data;
  logic [DEV_W-1:0] i_dev;
  logic             i_broadcast;

  modport master (output i_valid, i_addr, i_data, i_dev, i_broadcast, input o_ready);
  modport slave  (input i_valid, i_addr, i_data, i_dev, i_broadcast, output o_ready);
endinterface

// File: rtl/max7219_chain_tx_phase_timer.sv
// max7219_phase_timer: counts CLK_DIV clock cycles per SCLK half-period.
//   i_clk      system clock
//   i_reset    asynchronous reset, active high
//   run        count while high; held at zero while low
//   phase_end  strobe in the last cycle of each CLK_DIV-cycle phase
module max7219_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic run,
  output logic phase_end
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Phase counter: wraps at CLK_DIV-1, restarts from zero whenever run drops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_r <= '0;
    end else if (!run) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign phase_end = run && (cnt_r == LAST);

endmodule

// File: rtl/max7219_chain_tx.sv
// max7219_chain_tx: serial transmitter for a cascade of NUM_DEVICES MAX7219s.
// Each accepted write sends one full chain frame: the target device gets
// {4'h0, addr, data}, all others a no-op; broadcast gives every device the word.
//   i_clk, i_reset   system clock, asynchronous active-high reset
//   bus (slave)      i_valid/o_ready handshake plus i_addr, i_data, i_dev, i_broadcast
//   o_serial_load    LOAD/CS: idle high, low while shifting, rising edge latches
//   o_serial_dout    serial data, MSB first, device NUM_DEVICES-1 first
//   o_serial_clk     SCLK: idle low, slave samples on the rising edge
//   o_done           one-cycle pulse in the cycle LOAD rises
module max7219_chain_tx
  import max7219_pkg::*;
#(
  parameter int NUM_DEVICES = 1,
  parameter int CLK_DIV     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  max7219_chain_tx_if.slave    bus,
  output logic                 o_serial_load,
  output logic                 o_serial_dout,
  output logic                 o_serial_clk,
  output logic                 o_done
);
  localparam int FRAME_W = 16 * NUM_DEVICES;
  localparam int BIT_W   = $clog2(FRAME_W);

  state_t               state_r, state_next_s;
  logic [FRAME_W-1:0]   shift_r, shift_next_s, frame_s;
  logic [BIT_W-1:0]     bit_r, bit_next_s;
  logic                 sclk_hi_r, sclk_hi_next_s;
  logic                 accept_s, phase_end_s, run_s;
  logic                 load_next_s, sclk_next_s, dout_next_s, ready_next_s, done_next_s;
  logic                 load_r, sclk_r, dout_r, ready_r, done_r;

  assign accept_s = bus.i_valid && ready_r;
  assign run_s    = (state_r != ST_IDLE);

  max7219_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .run       (run_s),
    .phase_end (phase_end_s)
  );

  // Frame builder: device k occupies bits [16k+15:16k], so the top word leaves first.
  // An out-of-range i_dev matches no slot and yields an all-no-op frame.
  always_comb begin
    frame_s = '0;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      if (bus.i_broadcast || (int'(bus.i_dev) == k)) begin
        frame_s[16*k +: 16] = reg_word(bus.i_addr, bus.i_data);
      end else begin
        frame_s[16*k +: 16] = 16'h0000;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_r     <= '0;
      sclk_hi_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      shift_r   <= shift_next_s;
      bit_r     <= bit_next_s;
      sclk_hi_r <= sclk_hi_next_s;
    end
  end

  // Next-state logic. LATCH is the first cycle of the load-high gap, so the
  // timer keeps running through it and GAP ends on the same phase boundary.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_SHIFT;
        else          state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (phase_end_s && sclk_hi_r && (bit_r == '0)) state_next_s = ST_TAIL;
        else                                           state_next_s = ST_SHIFT;
      end
      ST_TAIL: begin
        if (phase_end_s) state_next_s = ST_LATCH;
        else             state_next_s = ST_TAIL;
      end
      ST_LATCH: begin
        if (phase_end_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_GAP;
      end
      ST_GAP: begin
        if (phase_end_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_GAP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath: load frame on accept; advance one bit at the end of each high phase.
  always_comb begin
    shift_next_s   = shift_r;
    bit_next_s     = bit_r;
    sclk_hi_next_s = sclk_hi_r;
    if (accept_s) begin
      shift_next_s   = frame_s;
      bit_next_s     = BIT_W'(FRAME_W - 1);
      sclk_hi_next_s = 1'b0;
    end else if ((state_r == ST_SHIFT) && phase_end_s) begin
      if (sclk_hi_r) begin
        sclk_hi_next_s = 1'b0;
        if (bit_r != '0) begin
          shift_next_s = {shift_r[FRAME_W-2:0], 1'b0};
          bit_next_s   = bit_r - BIT_W'(1);
        end else begin
          shift_next_s = shift_r;
        end
      end else begin
        sclk_hi_next_s = 1'b1;
      end
    end else begin
      sclk_hi_next_s = sclk_hi_r;
    end
  end

  // Output decode from next-state values so the registered pins line up with the state.
  always_comb begin
    load_next_s  = 1'b1;
    sclk_next_s  = 1'b0;
    dout_next_s  = 1'b0;
    ready_next_s = 1'b0;
    done_next_s  = 1'b0;
    case (state_next_s)
      ST_IDLE:  ready_next_s = 1'b1;
      ST_SHIFT: begin
        load_next_s = 1'b0;
        sclk_next_s = sclk_hi_next_s;
        dout_next_s = shift_next_s[FRAME_W-1];
      end
      ST_TAIL:  load_next_s = 1'b0;
      ST_LATCH: done_next_s = 1'b1;
      ST_GAP:   load_next_s = 1'b1;
      default:  load_next_s = 1'b1;
    endcase
  end

  // Output registers; reset forces the idle pin levels immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      load_r  <= 1'b1;
      sclk_r  <= 1'b0;
      dout_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      load_r  <= load_next_s;
      sclk_r  <= sclk_next_s;
      dout_r  <= dout_next_s;
      ready_r <= ready_next_s;
      done_r  <= done_next_s;
    end
  end

  assign o_serial_load = load_r;
  assign o_serial_clk  = sclk_r;
  assign o_serial_dout = dout_r;
  assign o_done        = done_r;
  assign bus.o_ready   = ready_r;

endmodule

// File: tb/tb_max7219_chain_tx.sv
// Bench for max7219_chain_tx: a 1-device and a 4-device chain (CLK_DIV=2),
// decoded by a per-device 16-bit shift model latched on LOAD rising.
module tb_max7219_chain_tx;
  logic refclk = 1'b0;
  logic rst1 = 1'b0;
  logic rst4 = 1'b0;
  logic load1, dout1, sclk1, done1;
  logic load4, dout4, sclk4, done4;

  always #5 refclk = ~refclk;

  max7219_chain_tx_if #(.DEV_W(1)) bus1 ();
  max7219_chain_tx_if #(.DEV_W(3)) bus4 ();

  max7219_chain_tx #(.NUM_DEVICES(1), .CLK_DIV(2)) dut1 (
    .i_clk(refclk), .i_reset(rst1), .bus(bus1),
    .o_serial_load(load1), .o_serial_dout(dout1), .o_serial_clk(sclk1), .o_done(done1));

  max7219_chain_tx #(.NUM_DEVICES(4), .CLK_DIV(2)) dut4 (
    .i_clk(refclk), .i_reset(rst4), .bus(bus4),
    .o_serial_load(load4), .o_serial_dout(dout4), .o_serial_clk(sclk4), .o_done(done4));

  int passed = 0;
  int total  = 0;

  // Chain model for the single device
  logic [15:0] sh1 = 16'h0000, lat1 = 16'h0000;
  logic ps1 = 1'b0, pl1 = 1'b1;
  int rises1 = 0, dones1 = 0, rlow1 = 0, dbad1 = 0;

  always @(negedge refclk) begin
    ps1 <= sclk1;
    pl1 <= load1;
    if (sclk1 && !ps1) begin
      sh1    <= {sh1[14:0], dout1};
      rises1 <= rises1 + 1;
    end
    if (load1 && !pl1) lat1 <= sh1;
    if (done1) dones1 <= dones1 + 1;
    if (!bus1.o_ready) rlow1 <= rlow1 + 1;
    if (load1 && dout1) dbad1 <= dbad1 + 1;
  end

  // Chain model for four devices: device 0 takes DIN, each passes its MSB on
  logic [15:0] sh4 [4] = '{default: 16'h0000};
  logic ps4 = 1'b0, pl4 = 1'b1;
  int rises4 = 0, dones4 = 0, rlow4 = 0, rhigh4 = 0, dbad4 = 0, hi4 = 0;
  logic [63:0] latq4 [$];
  int hiq4 [$];

  always @(negedge refclk) begin
    ps4 <= sclk4;
    pl4 <= load4;
    if (sclk4 && !ps4) begin
      sh4[0] <= {sh4[0][14:0], dout4};
      for (int k = 1; k < 4; k++) sh4[k] <= {sh4[k][14:0], sh4[k-1][15]};
      rises4 <= rises4 + 1;
    end
    if (load4 && !pl4) latq4.push_back({sh4[3], sh4[2], sh4[1], sh4[0]});
    if (!load4 && pl4) hiq4.push_back(hi4);
    hi4 <= load4 ? hi4 + 1 : 0;
    if (done4) dones4 <= dones4 + 1;
    if (!bus4.o_ready) rlow4 <= rlow4 + 1;
    else rhigh4 <= rhigh4 + 1;
    if (load4 && dout4) dbad4 <= dbad4 + 1;
  end

  // Snapshots taken right after each accept
  int b_rises1, b_dones1, b_rlow1, b_rises4, b_dones4, b_rlow4, b_rhigh4, b_latq4, b_hiq4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp4(input int dev, input bit bc, input logic [3:0] a, input logic [7:0] d);
    logic [63:0] r = 64'h0;
    for (int k = 0; k < 4; k++)
      if (bc || dev == k) r[16*k +: 16] = {4'h0, a, d};
    return r;
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 1) ? bus1.o_ready : bus4.o_ready;
  endfunction

  task automatic snap();
    b_rises1 = rises1; b_dones1 = dones1; b_rlow1 = rlow1;
    b_rises4 = rises4; b_dones4 = dones4; b_rlow4 = rlow4; b_rhigh4 = rhigh4;
    b_latq4 = latq4.size(); b_hiq4 = hiq4.size();
  endtask

  task automatic drive(input int sel, input int dev, input bit bc, input logic [3:0] a, input logic [7:0] d);
    if (sel == 1) begin
      bus1.i_valid = 1'b1; bus1.i_dev = 1'(dev); bus1.i_broadcast = bc; bus1.i_addr = a; bus1.i_data = d;
    end else begin
      bus4.i_valid = 1'b1; bus4.i_dev = 3'(dev); bus4.i_broadcast = bc; bus4.i_addr = a; bus4.i_data = d;
    end
  endtask

  // Present a write when ready, drop valid after the accept edge and scramble the fields
  task automatic send(input int sel, input int dev, input bit bc, input logic [3:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge refclk);
      if (ready_of(sel)) begin ok = 1'b1; break; end
    end
    chk("send_ready_timeout", 64'(ok), 64'd1);
    drive(sel, dev, bc, a, d);
    @(posedge refclk); #1;
    drive(sel, int'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 8'($urandom));
    if (sel == 1) bus1.i_valid = 1'b0; else bus4.i_valid = 1'b0;
    snap();
  endtask

  task automatic wait_ready(input int sel);
    bit ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge refclk);
      if (ready_of(sel)) begin ok = 1'b1; break; end
    end
    chk("frame_end_timeout", 64'(ok), 64'd1);
    repeat (2) @(posedge refclk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dev;
    bit bc;
    logic [3:0] a;
    logic [7:0] d;
    bit ok;

    bus1.i_valid = 1'b0; bus1.i_dev = 1'b0; bus1.i_broadcast = 1'b0; bus1.i_addr = 4'h0; bus1.i_data = 8'h00;
    bus4.i_valid = 1'b0; bus4.i_dev = 3'd0; bus4.i_broadcast = 1'b0; bus4.i_addr = 4'h0; bus4.i_data = 8'h00;
    rst1 = 1'b1;
    rst4 = 1'b1;
    repeat (3) @(negedge refclk);
    chk("rst1_load", 64'(load1), 64'd1);
    chk("rst1_sclk", 64'(sclk1), 64'd0);
    chk("rst1_dout", 64'(dout1), 64'd0);
    chk("rst1_ready", 64'(bus1.o_ready), 64'd1);
    chk("rst1_done", 64'(done1), 64'd0);
    chk("rst4_load", 64'(load4), 64'd1);
    chk("rst4_sclk", 64'(sclk4), 64'd0);
    chk("rst4_ready", 64'(bus4.o_ready), 64'd1);
    rst1 = 1'b0;
    rst4 = 1'b0;
    repeat (2) @(negedge refclk);

    // 1: single device, DIGIT0 = 7E
    send(1, 0, 1'b0, 4'h1, 8'h7E);
    wait_ready(1);
    chk("t1_word", 64'(lat1), 64'h017E);
    chk("t1_rises", 64'(rises1 - b_rises1), 64'd16);
    chk("t1_done", 64'(dones1 - b_dones1), 64'd1);
    chk("t1_ready_low", 64'(rlow1 - b_rlow1), 64'd68);

    // 2: four devices, device 2 only
    send(4, 2, 1'b0, 4'h3, 8'h5B);
    wait_ready(4);
    chk("t2_frame", latq4[latq4.size()-1], 64'h0000_035B_0000_0000);
    chk("t2_rises", 64'(rises4 - b_rises4), 64'd64);
    chk("t2_done", 64'(dones4 - b_dones4), 64'd1);
    chk("t2_ready_low", 64'(rlow4 - b_rlow4), 64'd260);

    // 3: broadcast shutdown register
    send(4, 1, 1'b1, 4'hC, 8'h01);
    wait_ready(4);
    chk("t3_frame", latq4[latq4.size()-1], 64'h0C01_0C01_0C01_0C01);

    // 4: valid held high across three writes
    send(4, 0, 1'b0, 4'h1, 8'h11);
    bus4.i_valid = 1'b1;
    for (int i = 1; i < 3; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge refclk);
        if (bus4.o_ready) begin
          if (i == 1) drive(4, 3, 1'b0, 4'hA, 8'h0F);
          else        drive(4, 0, 1'b1, 4'hB, 8'h07);
          ok = 1'b1;
          break;
        end
      end
      chk("t4_accept_timeout", 64'(ok), 64'd1);
      @(posedge refclk); #1;
    end
    chk("t4_ready_high_cycles", 64'(rhigh4 - b_rhigh4), 64'd2);
    bus4.i_valid = 1'b0;
    wait_ready(4);
    chk("t4_done", 64'(dones4 - b_dones4), 64'd3);
    chk("t4_latches", 64'(latq4.size() - b_latq4), 64'd3);
    chk("t4_frame0", latq4[b_latq4],     exp4(0, 1'b0, 4'h1, 8'h11));
    chk("t4_frame1", latq4[b_latq4 + 1], exp4(3, 1'b0, 4'hA, 8'h0F));
    chk("t4_frame2", latq4[b_latq4 + 2], exp4(0, 1'b1, 4'hB, 8'h07));
    chk("t4_load_gaps", 64'(hiq4.size() - b_hiq4), 64'd3);
    chk("t4_gap1_ge3", 64'(hiq4[b_hiq4 + 1] >= 3), 64'd1);
    chk("t4_gap2_ge3", 64'(hiq4[b_hiq4 + 2] >= 3), 64'd1);

    // 5: reset during bit 7 of a single-device frame
    send(1, 0, 1'b0, 4'h5, 8'hFF);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge refclk); #1;
      if (rises1 - b_rises1 >= 8) begin ok = 1'b1; break; end
    end
    chk("t5_bit7_timeout", 64'(ok), 64'd1);
    repeat (2) @(posedge refclk);
    #2;
    rst1 = 1'b1;
    #1;
    chk("t5_load", 64'(load1), 64'd1);
    chk("t5_sclk", 64'(sclk1), 64'd0);
    chk("t5_dout", 64'(dout1), 64'd0);
    chk("t5_ready", 64'(bus1.o_ready), 64'd1);
    repeat (2) @(negedge refclk);
    rst1 = 1'b0;
    send(1, 0, 1'b0, 4'hA, 8'h0F);
    wait_ready(1);
    chk("t5_word_after_reset", 64'(lat1), 64'h0A0F);
    chk("t5_done", 64'(dones1 - b_dones1), 64'd1);

    // 6: device index beyond the chain -> all no-ops, full length
    send(4, 5, 1'b0, 4'h3, 8'hAA);
    wait_ready(4);
    chk("t6_frame", latq4[latq4.size()-1], 64'h0);
    chk("t6_rises", 64'(rises4 - b_rises4), 64'd64);
    chk("t6_ready_low", 64'(rlow4 - b_rlow4), 64'd260);

    // Randomized writes on the four-device chain
    for (int i = 0; i < 6; i++) begin
      dev = int'($urandom_range(0, 7));
      bc  = ($urandom_range(0, 3) == 0);
      a   = 4'($urandom_range(0, 15));
      d   = 8'($urandom);
      send(4, dev, bc, a, d);
      wait_ready(4);
      chk("rand_frame", latq4[latq4.size()-1], exp4(dev, bc, a, d));
    end

    // Randomized writes on the single device (i_dev=1 is out of range there)
    for (int i = 0; i < 4; i++) begin
      dev = int'($urandom_range(0, 1));
      bc  = 1'($urandom);
      a   = 4'($urandom_range(0, 15));
      d   = 8'($urandom);
      send(1, dev, bc, a, d);
      wait_ready(1);
      chk("rand1_word", 64'(lat1), (bc || dev == 0) ? 64'({4'h0, a, d}) : 64'h0);
    end

    chk("dout1_zero_while_load_high", 64'(dbad1), 64'd0);
    chk("dout4_zero_while_load_high", 64'(dbad4), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
